instr_cache_refill: RTL and testbench

- Direct-mapped instruction cache between the fetch-stage PC register and a 32-bit backing instruction memory.
- Every cycle it returns one 32-bit fetch word for the current PC. The word packs two 16-bit instructions: [31:16] is the memory slot and [15:0] is the ALU slot.
- On a miss, a state machine refills the whole line from backing memory with a req/ready handshake.
- The hit flag drives PC/pipeline stall gating in the fetch stage.

---
 rtl/instr_cache_refill.sv | 168 ++++++++++++++++
 tb/tb_instr_cache_refill.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_refill.sv
// Direct-mapped instruction cache with four-word lines. Lookups are combinational;
// a miss starts an in-order refill of the whole line using a req/ready handshake.
module instr_cache_refill #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        invalidate,
  output logic        hit,
  output logic [31:0] instr2Word,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [1:0]              beat_r;
  logic [TAG_BITS-1:0]     miss_tag_r;
  logic [INDEX_BITS-1:0]   miss_index_r;
  logic                    kill_r;
  logic [LINES-1:0]        valid_r;
  logic [TAG_BITS-1:0]     tag_r [LINES];
  logic [31:0]             data_r [LINES][4];
  logic                    mem_req_r;
  logic [31:0]             mem_addr_r;

  logic [1:0]              offset_s;
  logic [INDEX_BITS-1:0]   index_s;
  logic [TAG_BITS-1:0]     tag_s;
  logic                    lookup_hit_s;
  logic                    start_s;
  logic                    beat_we_s;
  logic                    last_beat_s;
  logic                    unused_pc_bits_s;

  assign offset_s         = pc[3:2];
  assign index_s          = pc[INDEX_BITS+3:4];
  assign tag_s            = pc[31:INDEX_BITS+4];
  assign unused_pc_bits_s = ^pc[1:0];

  // Lookup is suppressed outside IDLE so a pc aliasing the line in flight never hits.
  assign lookup_hit_s = (state_r == IDLE) && valid_r[index_s] && (tag_r[index_s] == tag_s);

  // Fetch word or bubble for the current pc.
  always_comb begin
    hit        = lookup_hit_s;
    instr2Word = 32'h0000_0000;
    if (lookup_hit_s) begin
      instr2Word = data_r[index_s][offset_s];
    end else begin
      instr2Word = 32'h0000_0000;
    end
  end

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start_s ? REFILL : IDLE;
      REFILL:  state_next_s = last_beat_s ? IDLE : REFILL;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM control outputs: refill start, beat write strobe, final beat.
  always_comb begin
    start_s     = 1'b0;
    beat_we_s   = 1'b0;
    last_beat_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!lookup_hit_s && !invalidate) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      REFILL: begin
        beat_we_s   = mem_ready;
        last_beat_s = mem_ready && (beat_r == 2'd3);
      end
      default: begin
        start_s     = 1'b0;
        beat_we_s   = 1'b0;
        last_beat_s = 1'b0;
      end
    endcase
  end

  // Refill bookkeeping and the registered memory request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_r       <= 2'd0;
      miss_tag_r   <= '0;
      miss_index_r <= '0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
    end else if (start_s) begin
      beat_r       <= 2'd0;
      miss_tag_r   <= tag_s;
      miss_index_r <= index_s;
      mem_req_r    <= 1'b1;
      mem_addr_r   <= {pc[31:4], 4'h0};
    end else if (beat_we_s) begin
      beat_r       <= beat_r + 2'd1;
      mem_req_r    <= !last_beat_s;
      mem_addr_r   <= mem_addr_r + 32'd4;
    end
  end

  // Any invalidate seen during a refill keeps the fetched line from becoming valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_r <= 1'b0;
    end else if (start_s) begin
      kill_r <= 1'b0;
    end else if (state_r == REFILL && invalidate) begin
      kill_r <= 1'b1;
    end
  end

  // Valid bits: invalidate takes priority over the final-beat set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
    end else if (invalidate) begin
      valid_r <= '0;
    end else if (start_s) begin
      valid_r[index_s] <= 1'b0;
    end else if (last_beat_s && !kill_r) begin
      valid_r[miss_index_r] <= 1'b1;
    end
  end

  // Data and tag storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (beat_we_s) begin
      data_r[miss_index_r][beat_r] <= mem_rdata;
    end
    if (last_beat_s) begin
      tag_r[miss_index_r] <= miss_tag_r;
    end
  end

endmodule

// File: tb/tb_instr_cache_refill.sv
// Bench for instr_cache_refill: directed scenarios plus random traffic, all checked
// against a line-level model in which a valid line simply mirrors backing memory.
module tb_instr_cache_refill;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        invalidate;
  logic        hit;
  logic [31:0] instr2Word;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Model state
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  bit          m_busy;
  bit          m_kill;
  logic [31:0] m_base;
  int          m_beats;

  instr_cache_refill #(.INDEX_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .invalidate (invalidate),
    .hit        (hit),
    .instr2Word (instr2Word),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + ((a - 32'h0000_0100) >> 2);
  endfunction

  assign mem_rdata = mem_ready ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_busy  = 1'b0;
    m_kill  = 1'b0;
    m_beats = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] p);
    return !m_busy && m_valid[p[7:4]] && (m_tag[p[7:4]] == p[31:8]);
  endfunction

  // One clock: apply inputs, check outputs at negedge, advance model at posedge.
  task automatic cycle(input logic [31:0] p, input logic inv, input logic rdy);
    bit eh;
    pc = p; invalidate = inv; mem_ready = rdy;
    @(negedge clk);
    eh = model_hit(p);
    check_val("hit", 32'(hit), 32'(eh));
    check_val("instr2Word", instr2Word, eh ? mem_word({p[31:2], 2'b00}) : 32'h0);
    check_val("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) check_val("mem_addr", mem_addr, m_base + 32'(m_beats * 4));
    @(posedge clk);
    if (!m_busy) begin
      if (inv) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (!eh) begin
        m_busy = 1'b1; m_kill = 1'b0; m_beats = 0;
        m_base = {p[31:4], 4'h0};
        m_valid[p[7:4]] = 1'b0;
      end
    end else begin
      if (inv) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_kill = 1'b1;
      end
      if (rdy) begin
        m_beats++;
        if (m_beats == 4) begin
          m_busy = 1'b0;
          if (!m_kill) begin
            m_valid[m_base[7:4]] = 1'b1;
            m_tag[m_base[7:4]]   = m_base[31:8];
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    bit          rdy_seq [7];
    reset = 1'b1; pc = 32'h0; invalidate = 1'b0; mem_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_val("rst_hit", 32'(hit), 32'h0);
    check_val("rst_word", instr2Word, 32'h0);
    check_val("rst_req", 32'(mem_req), 32'h0);
    check_val("rst_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cold miss at 0x100
    cycle(32'h100, 1'b0, 1'b1);
    check_val("cold_addr0", mem_addr, 32'h100);
    check_val("cold_req0", 32'(mem_req), 32'h1);
    for (int i = 0; i < 4; i++) cycle(32'h100, 1'b0, 1'b1);
    #1;
    check_val("cold_hit", 32'(hit), 32'h1);
    check_val("cold_word0", instr2Word, 32'hA000_0000);
    pc = 32'h10C; #1;
    check_val("cold_word3", instr2Word, 32'hA000_0003);
    cycle(32'h10C, 1'b0, 1'b1);

    // Wait states at 0x200
    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cycle(32'h200, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(32'h200, 1'b0, rdy_seq[i]);
    cycle(32'h208, 1'b0, 1'b0);

    // Conflict eviction on index 0
    for (int i = 0; i < 6; i++) cycle(32'h1100, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(32'h100, 1'b0, 1'b1);

    // PC moves mid-refill
    cycle(32'h300, 1'b0, 1'b1);
    cycle(32'h300, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(32'h400, 1'b0, 1'b1);

    // Invalidate in IDLE, then invalidate on the final beat
    cycle(32'h100, 1'b0, 1'b1);
    cycle(32'h100, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(32'h100, (i == 4), 1'b1);
    for (int i = 0; i < 6; i++) cycle(32'h100, 1'b0, 1'b1);

    // Reset during beat 2
    cycle(32'h300, 1'b0, 1'b1);
    cycle(32'h300, 1'b0, 1'b1);
    cycle(32'h300, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_req", 32'(mem_req), 32'h0);
    check_val("async_hit", 32'(hit), 32'h0);
    check_val("async_addr", mem_addr, 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cycle(32'h300, 1'b0, 1'b1);

    // Random traffic
    rpc = 32'h100;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        rpc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) |
              (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) rpc = rpc | 32'h0001_1000;
      end
      cycle(rpc, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
